// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/LSU memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/owner_fifo.sv
// Small circular FIFO recording which requester owns each outstanding transaction.
module owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = owner_e
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    T              r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign rdata  = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= next_ptr(r_wptr);
            if (w_pop)  r_rptr <= next_ptr(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one OBI-style memory port between fetch and LSU, with starvation
// protection for fetch and in-order response routing via an owner FIFO.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTST    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        proto_err_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] r_starve;
    logic          r_proto_err;

    logic   w_full;
    logic   w_empty;
    logic   w_any_req;
    logic   w_starved;
    logic   w_sel_instr;
    logic   w_accept;
    logic   w_pop;
    logic   w_rsp_instr;
    logic   w_rsp_data;
    owner_e w_head;
    owner_e w_push_owner;

    assign w_any_req = instr_req_i | data_req_i;
    assign w_starved = (r_starve == SW'(STARVE_LIMIT));
    // Gating on instr_req_i keeps a stale saturated count from stealing the port.
    assign w_sel_instr = ~data_req_i | (instr_req_i & w_starved);

    assign mem_req_o   = w_any_req & ~w_full;
    assign mem_we_o    = ~w_sel_instr & data_we_i;
    assign mem_be_o    = !w_any_req ? 4'h0 : (w_sel_instr ? BE_ALL : data_be_i);
    assign mem_addr_o  = !w_any_req ? 32'h0 : (w_sel_instr ? instr_addr_i : data_addr_i);
    assign mem_wdata_o = w_sel_instr ? 32'h0 : data_wdata_i;

    assign w_accept     = mem_req_o & mem_gnt_i;
    assign instr_gnt_o  = w_accept & w_sel_instr;
    assign data_gnt_o   = w_accept & ~w_sel_instr;
    assign w_push_owner = w_sel_instr ? OWN_INSTR : OWN_DATA;

    assign w_pop       = mem_rvalid_i & ~w_empty;
    assign w_rsp_instr = w_pop & (w_head == OWN_INSTR);
    assign w_rsp_data  = w_pop & (w_head == OWN_DATA);

    assign instr_rvalid_o = w_rsp_instr;
    assign instr_rdata_o  = w_rsp_instr ? mem_rdata_i : 32'h0;
    assign instr_err_o    = w_rsp_instr & mem_err_i;
    assign data_rvalid_o  = w_rsp_data;
    assign data_rdata_o   = w_rsp_data ? mem_rdata_i : 32'h0;
    assign data_err_o     = w_rsp_data & mem_err_i;
    assign proto_err_o    = r_proto_err;

    owner_fifo #(
        .DEPTH (MAX_OUTST),
        .T     (owner_e)
    ) u_owner_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_accept),
        .pop   (w_pop),
        .wdata (w_push_owner),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (instr_req_i && !instr_gnt_o) begin
                if (!w_starved) r_starve <= r_starve + 1'b1;
            end else begin
                r_starve <= '0;
            end
            if (mem_rvalid_i && w_empty) r_proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, starvation, full/empty, routing, reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        proto_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_OUTST    (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i),
        .proto_err_o    (proto_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        mem_err_i    = 1'b0;
    endtask

    logic exp_instr;
    logic prev_instr;

    initial begin
        rstn = 1'b0;
        idle();
        #12;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_be", mem_be_o, 0);
        check("rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
        check("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
        check("rst_proto", proto_err_o, 0);
        rstn = 1'b1;

        // Fetch only, response next cycle
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
        #1;
        check("f_mem_req", mem_req_o, 1);
        check("f_mem_addr", mem_addr_o, 32'h100);
        check("f_mem_be", mem_be_o, 4'hF);
        check("f_mem_we", mem_we_o, 0);
        check("f_instr_gnt", instr_gnt_o, 1);
        check("f_data_gnt", data_gnt_o, 0);
        tick();
        idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
        #1;
        check("f_instr_rv", instr_rvalid_o, 1);
        check("f_instr_rd", instr_rdata_o, 32'h13);
        check("f_data_rv", data_rvalid_o, 0);
        check("f_data_rd", data_rdata_o, 0);
        tick();
        idle();
        #1;
        check("f_proto", proto_err_o, 0);

        // Both requesting every cycle: fetch wins every fifth cycle
        prev_instr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            instr_req_i = 1'b1; instr_addr_i = 32'h200;
            data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
            data_addr_i = 32'h300; data_wdata_i = 32'hDEAD_0000 + k;
            mem_gnt_i = 1'b1; mem_rvalid_i = (k > 0); mem_rdata_i = k;
            #1;
            exp_instr = ((k % 5) == 4);
            check("sv_instr_gnt", instr_gnt_o, exp_instr);
            check("sv_data_gnt", data_gnt_o, !exp_instr);
            check("sv_mem_be", mem_be_o, exp_instr ? 32'hF : 32'h3);
            check("sv_mem_wdata", mem_wdata_o, exp_instr ? 32'h0 : 32'hDEAD_0000 + k);
            if (k > 0) begin
                check("sv_instr_rv", instr_rvalid_o, prev_instr);
                check("sv_data_rv", data_rvalid_o, !prev_instr);
            end
            prev_instr = exp_instr;
        end
        tick();
        idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
        #1;
        check("sv_drain_irv", instr_rvalid_o, 1);
        check("sv_drain_ird", instr_rdata_o, 32'h55);
        tick();
        idle();

        // Fill: data then instr, no responses
        instr_req_i = 1'b1; instr_addr_i = 32'h400;
        data_req_i = 1'b1; data_addr_i = 32'h500; data_be_i = 4'hF; mem_gnt_i = 1'b1;
        #1;
        check("fl_data_gnt", data_gnt_o, 1);
        tick();
        data_req_i = 1'b0;
        #1;
        check("fl_instr_gnt", instr_gnt_o, 1);
        tick();
        data_req_i = 1'b1;
        #1;
        check("fl_full_req", mem_req_o, 0);
        check("fl_full_gnts", {instr_gnt_o, data_gnt_o}, 0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAA;
        #1;
        check("fl_pop_req", mem_req_o, 0);
        check("fl_rsp1_drv", data_rvalid_o, 1);
        check("fl_rsp1_drd", data_rdata_o, 32'hAA);
        check("fl_rsp1_irv", instr_rvalid_o, 0);
        check("fl_rsp1_ird", instr_rdata_o, 0);
        tick();
        idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBB;
        #1;
        check("fl_rsp2_irv", instr_rvalid_o, 1);
        check("fl_rsp2_ird", instr_rdata_o, 32'hBB);
        check("fl_rsp2_drv", data_rvalid_o, 0);
        tick();
        idle();

        // Push and pop together at count 1; error response on LSU
        data_req_i = 1'b1; data_addr_i = 32'h600; mem_gnt_i = 1'b1;
        #1;
        check("pp_data_gnt", data_gnt_o, 1);
        tick();
        data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h700;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1;
        #1;
        check("pp_instr_gnt", instr_gnt_o, 1);
        check("pp_rsp1_drv", data_rvalid_o, 1);
        check("pp_rsp1_drd", data_rdata_o, 32'h1);
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b1; mem_rdata_i = 32'h2;
        #1;
        check("pp_not_full", mem_req_o, 1);
        check("pp_data_gnt2", data_gnt_o, 1);
        check("pp_rsp2_irv", instr_rvalid_o, 1);
        check("pp_rsp2_ird", instr_rdata_o, 32'h2);
        check("pp_rsp2_drv", data_rvalid_o, 0);
        tick();
        idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3; mem_err_i = 1'b1;
        #1;
        check("er_data_rv", data_rvalid_o, 1);
        check("er_data_err", data_err_o, 1);
        check("er_instr_err", instr_err_o, 0);
        check("er_data_rd", data_rdata_o, 32'h3);
        tick();
        idle();
        #1;
        check("pp_proto", proto_err_o, 0);

        // Response with empty FIFO
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
        #1;
        check("em_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
        tick();
        idle();
        #1;
        check("em_proto_set", proto_err_o, 1);
        tick();
        tick();
        tick();
        check("em_proto_sticky", proto_err_o, 1);

        // Saturate starve, fill FIFO, then reset mid-operation
        instr_req_i = 1'b1; instr_addr_i = 32'h800;
        data_req_i = 1'b1; data_addr_i = 32'h900; data_be_i = 4'hF;
        for (int k = 0; k < 5; k++) tick();
        mem_gnt_i = 1'b1;
        #1;
        check("rm_starved_gnt", instr_gnt_o, 1);
        tick();
        #1;
        check("rm_data_gnt", data_gnt_o, 1);
        tick();
        mem_gnt_i = 1'b0;
        tick();
        tick();
        tick();
        #1;
        check("rm_full_req", mem_req_o, 0);
        check("rm_starved_addr", mem_addr_o, 32'h800);
        check("rm_proto_pre", proto_err_o, 1);
        rstn = 1'b0;
        #1;
        check("rm_rst_req", mem_req_o, 1);
        check("rm_rst_addr", mem_addr_o, 32'h900);
        check("rm_rst_proto", proto_err_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
        #1;
        check("rm_stale_rv", {instr_rvalid_o, data_rvalid_o}, 0);
        tick();
        idle();
        #1;
        check("rm_stale_proto", proto_err_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
